// File: rtl/dcc_pkg.sv
// Shared constants, FSM state type and slice-offset helpers for the delta-color-compression decoder.
package dcc_pkg;

  localparam int unsigned DCC_CH_BITS   = 8;
  localparam int unsigned DCC_CHANNELS  = 4;
  localparam int unsigned DCC_BLOCK_DIM = 4;
  localparam int unsigned DCC_ROWS      = 4;

  typedef enum logic {
    EMPTY,
    EMIT
  } dcc_state_e;

  function automatic int unsigned dcc_px_off(input int unsigned px);
    return px * DCC_CH_BITS * DCC_CHANNELS;
  endfunction

  function automatic int unsigned dcc_ch_off(input int unsigned ch);
    return ch * DCC_CH_BITS;
  endfunction

  function automatic int unsigned dcc_delta_off(input int unsigned px, input int unsigned ch,
                                                input int unsigned delta_bits);
    return (px * DCC_CHANNELS + ch) * delta_bits;
  endfunction

endpackage

// File: rtl/dcc_px_recon.sv
// One-pixel reconstruction: each channel is base plus sign-extended delta, wrapping mod 256.
module dcc_px_recon
  import dcc_pkg::*;
#(
  parameter int unsigned DELTA_BITS = 4
) (
  input  logic [31:0]                           i_base,
  input  logic [DCC_CHANNELS*DELTA_BITS-1:0]    i_deltas,
  output logic [31:0]                           o_pixel
);

  for (genvar j = 0; j < DCC_CHANNELS; j++) begin : g_ch
    logic signed [DELTA_BITS-1:0] w_delta;
    assign w_delta = i_deltas[dcc_delta_off(0, j, DELTA_BITS) +: DELTA_BITS];
    // Signed size cast sign-extends; the 8-bit sum wraps naturally.
    assign o_pixel[dcc_ch_off(j) +: DCC_CH_BITS] =
      i_base[dcc_ch_off(j) +: DCC_CH_BITS] + DCC_CH_BITS'(w_delta);
  end

endmodule

// File: rtl/dcc_decoder.sv
// Delta-color-compression block decoder: reconstructs a 4x4 RGBA8 block at accept and streams it one row per beat.
module dcc_decoder
  import dcc_pkg::*;
#(
  parameter int unsigned PIXEL_BITS   = 32,
  parameter int unsigned BLOCK_PIXELS = 16,
  parameter int unsigned DELTA_BITS   = 4,
  parameter int unsigned ROW_PIXELS   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  blk_valid,
  output logic                                  blk_ready,
  input  logic                                  blk_compressed,
  input  logic [PIXEL_BITS-1:0]                 blk_base,
  input  logic [BLOCK_PIXELS*4*DELTA_BITS-1:0]  blk_deltas,
  input  logic [BLOCK_PIXELS*PIXEL_BITS-1:0]    blk_raw,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ROW_PIXELS*PIXEL_BITS-1:0]      out_row,
  output logic [1:0]                            out_row_idx,
  output logic                                  out_last,
  output logic                                  out_was_compressed,
  output logic [15:0]                           stat_comp_blocks,
  output logic [15:0]                           stat_raw_blocks
);

  dcc_state_e                        r_state;
  logic [1:0]                        r_row;
  logic                              r_comp;
  logic [ROW_PIXELS*PIXEL_BITS-1:0]  r_hold [DCC_ROWS];
  logic [15:0]                       r_stat_comp;
  logic [15:0]                       r_stat_raw;

  logic [PIXEL_BITS-1:0]             w_recon [BLOCK_PIXELS];
  logic [ROW_PIXELS*PIXEL_BITS-1:0]  w_rows  [DCC_ROWS];
  logic                              w_emit;
  logic                              w_done;
  logic                              w_accept;

  for (genvar p = 0; p < BLOCK_PIXELS; p++) begin : g_px
    dcc_px_recon #(
      .DELTA_BITS (DELTA_BITS)
    ) u_recon (
      .i_base   (blk_base),
      .i_deltas (blk_deltas[dcc_delta_off(p, 0, DELTA_BITS) +: DCC_CHANNELS*DELTA_BITS]),
      .o_pixel  (w_recon[p])
    );
  end

  always_comb begin
    w_rows = '{default: '0};
    for (int unsigned r = 0; r < DCC_ROWS; r++) begin
      for (int unsigned k = 0; k < ROW_PIXELS; k++) begin
        w_rows[r][k*PIXEL_BITS +: PIXEL_BITS] = blk_compressed
          ? w_recon[r*ROW_PIXELS + k]
          : blk_raw[dcc_px_off(r*ROW_PIXELS + k) +: PIXEL_BITS];
      end
    end
  end

  assign w_emit   = (r_state == EMIT);
  assign w_done   = w_emit && (r_row == 2'd3) && out_ready;
  assign blk_ready = (r_state == EMPTY) || w_done;
  assign w_accept = blk_valid && blk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_row       <= '0;
      r_comp      <= 1'b0;
      r_hold      <= '{default: '0};
      r_stat_comp <= '0;
      r_stat_raw  <= '0;
    end else begin
      if (w_done) begin
        if (r_comp) begin
          if (r_stat_comp != '1) r_stat_comp <= r_stat_comp + 16'd1;
        end else begin
          if (r_stat_raw != '1) r_stat_raw <= r_stat_raw + 16'd1;
        end
      end
      // A new block may land in the same cycle the row-3 beat retires: no bubble.
      if (w_accept) begin
        r_hold  <= w_rows;
        r_comp  <= blk_compressed;
        r_row   <= '0;
        r_state <= EMIT;
      end else if (w_emit && out_ready) begin
        if (r_row == 2'd3) begin
          r_state <= EMPTY;
          r_row   <= '0;
        end else begin
          r_row <= r_row + 2'd1;
        end
      end
    end
  end

  assign out_valid          = w_emit;
  assign out_row            = r_hold[r_row];
  assign out_row_idx        = r_row;
  assign out_last           = w_emit && (r_row == 2'd3);
  assign out_was_compressed = r_comp;
  assign stat_comp_blocks   = r_stat_comp;
  assign stat_raw_blocks    = r_stat_raw;

endmodule
